// File: rtl/seven_seg_display_driver_pkg.sv
// Shared types and constants for the seven-segment display driver:
// conversion FSM encoding, segment table and double-dabble helper.
package seven_seg_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } convState_t;

  localparam int DIGITS    = 4;
  localparam int BIN_BITS  = 14;
  localparam int BCD_BITS  = 16;
  localparam int CONV_BITS = BCD_BITS + BIN_BITS;

  localparam logic [BIN_BITS-1:0] MAX_DISPLAY = 14'd9999;
  localparam logic [6:0]          SEG_BLANK   = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the digit 0 pattern.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [BCD_BITS-1:0] dabbleAdjust(input logic [BCD_BITS-1:0] bcd);
    logic [BCD_BITS-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Codes 10..15 produce a blank digit.
module bcd_to_seg7
  import seven_seg_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Table lookup for decimal codes, blank otherwise.
  always_comb begin
    segments = SEG_BLANK;
    if (nibble < 4'd10) begin
      segments = SEG_TABLE[nibble];
    end else begin
      segments = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seven_seg_display_driver.sv
// Seven-segment driver: free-running binary-to-BCD conversion and 4-digit scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_display_driver
  import seven_seg_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] value,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [19:0] REFRESH_LAST = 20'(REFRESH_DIV - 1);
  localparam logic [3:0]  LAST_STEP    = 4'(BIN_BITS - 1);

  convState_t            state_r;
  logic [BIN_BITS-1:0]   binShift_r;
  logic [BCD_BITS-1:0]   bcd_r;
  logic [BCD_BITS-1:0]   dispReg_r;
  logic [3:0]            stepCnt_r;
  logic                  pending_r;
  logic                  busy_r;
  logic                  overflow_r;
  logic [19:0]           refreshCnt_r;
  logic [1:0]            digitIdx_r;
  logic [3:0]            an_r;
  logic [6:0]            seg_r;

  logic                  overRange_s;
  logic [BIN_BITS-1:0]   sample_s;
  logic [BCD_BITS-1:0]   bcdAdj_s;
  logic [CONV_BITS-1:0]  dabbleNext_s;
  logic [3:0]            curNibble_s;
  logic [6:0]            segDecoded_s;
  logic                  blank_s;

  // Saturate the incoming sample and form the next adjust-then-shift step.
  always_comb begin
    overRange_s = (value > MAX_DISPLAY);
    if (overRange_s) begin
      sample_s = MAX_DISPLAY;
    end else begin
      sample_s = value;
    end
    bcdAdj_s     = dabbleAdjust(bcd_r);
    dabbleNext_s = CONV_BITS'({bcdAdj_s, binShift_r, 1'b0});
  end

  // Conversion FSM: sample in IDLE, 14 double-dabble steps, then latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      binShift_r <= 14'd0;
      bcd_r      <= 16'd0;
      dispReg_r  <= 16'd0;
      stepCnt_r  <= 4'd0;
      pending_r  <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          binShift_r <= sample_s;
          pending_r  <= overRange_s;
          bcd_r      <= 16'd0;
          stepCnt_r  <= 4'd0;
          busy_r     <= 1'b1;
          state_r    <= SHIFT;
        end
        SHIFT: begin
          {bcd_r, binShift_r} <= dabbleNext_s;
          stepCnt_r <= stepCnt_r + 4'd1;
          busy_r    <= 1'b1;
          if (stepCnt_r == LAST_STEP) begin
            state_r <= LATCH;
          end else begin
            state_r <= SHIFT;
          end
        end
        LATCH: begin
          // Display only ever sees a fully converted value.
          dispReg_r  <= bcd_r;
          overflow_r <= pending_r;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    curNibble_s = dispReg_r[{digitIdx_r, 2'b00} +: 4];
  end

  bcd_to_seg7 u_bcdToSeg7 (
    .nibble   (curNibble_s),
    .segments (segDecoded_s)
  );

  // Leading-zero suppression: a digit is blank if it and everything left of it is zero.
  always_comb begin
    blank_s = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (digitIdx_r)
      2'd3:    blank_s = (dispReg_r[15:12] == 4'd0);
      2'd2:    blank_s = (dispReg_r[15:8] == 8'd0);
      2'd1:    blank_s = (dispReg_r[15:4] == 12'd0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
  end

  // Refresh timer, digit scan and registered anode/segment outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refreshCnt_r <= 20'd0;
      digitIdx_r   <= 2'd0;
      an_r         <= 4'b1111;
      seg_r        <= SEG_BLANK;
    end else begin
      if (refreshCnt_r == REFRESH_LAST) begin
        refreshCnt_r <= 20'd0;
        digitIdx_r   <= digitIdx_r + 2'd1;
      end else begin
        refreshCnt_r <= refreshCnt_r + 20'd1;
      end
      if (blank_s) begin
        an_r  <= 4'b1111;
        seg_r <= SEG_BLANK;
      end else begin
        an_r  <= ~(4'b0001 << digitIdx_r);
        seg_r <= segDecoded_s;
      end
    end
  end

  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign an       = an_r;
  assign seg      = seg_r;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver (REFRESH_DIV=4); expected
// digits come from decimal arithmetic on the applied value.
module tb_seven_seg_display_driver;

  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] value = 14'd0;
  logic        busy;
  logic        overflow;
  logic [3:0]  an;
  logic [6:0]  seg;

  int compared = 0;
  int mismatched = 0;

  logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seven_seg_display_driver #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .busy     (busy),
    .overflow (overflow),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1);
  end

  function automatic int satVal(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] expSeg(input int v, input int d);
    return segTab[(satVal(v) / pow10(d)) % 10];
  endfunction

  function automatic bit expLit(input int v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d == 0) || (satVal(v) >= pow10(d));
`else
    return 1'b1;
`endif
  endfunction

  // Move to a negedge where the converter sits in IDLE.
  task automatic align_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL align_idle: busy=%b, expected 0 within 40 cycles", busy);
    end
  endtask

  // Wait for one conversion to start and finish; report its busy length.
  task automatic wait_conv(output int busyCycles);
    int n = 0;
    busyCycles = 0;
    while (busy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (busy === 1'b1 && busyCycles < 40) begin
      @(negedge clk);
      busyCycles++;
    end
    if (busyCycles == 0 || busyCycles >= 40) begin
      compared++;
      mismatched++;
      $display("FAIL wait_conv: busy window=%0d cycles, expected 1..39", busyCycles);
    end
  endtask

  // Observe the scan for ncyc cycles, recording the pattern shown per digit.
  task automatic capture(input int ncyc, output logic [3:0][6:0] segs,
                         output logic [3:0] lit, output bit bad);
    segs = '1;
    lit = 4'b0000;
    bad = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin lit[0] = 1'b1; segs[0] = seg; end
        4'b1101: begin lit[1] = 1'b1; segs[1] = seg; end
        4'b1011: begin lit[2] = 1'b1; segs[2] = seg; end
        4'b0111: begin lit[3] = 1'b1; segs[3] = seg; end
        4'b1111: ;
        default: bad = 1'b1;
      endcase
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    value = 14'($urandom_range(0, 16383));
    repeat (3) @(negedge clk);
    compared += 4;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    if (an !== 4'b1111) begin mismatched++; $display("FAIL reset_an: got %b, expected 1111", an); end
    if (seg !== 7'b1111111) begin mismatched++; $display("FAIL reset_seg: got %b, expected 1111111", seg); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    compared += 3;
    if (an !== 4'b1110) begin mismatched++; $display("FAIL release_an: got %b, expected 1110", an); end
    if (seg !== 7'b1000000) begin mismatched++; $display("FAIL release_seg: got %b, expected 1000000", seg); end
    if (busy !== 1'b1) begin mismatched++; $display("FAIL release_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_busy_1234();
    int bc;
    logic [3:0][6:0] segs;
    logic [3:0] lit;
    bit bad;
    align_idle();
    value = 14'd1234;
    wait_conv(bc);
    compared++;
    if (bc != 15) begin mismatched++; $display("FAIL busy_len: got %0d cycles, expected 15", bc); end
    capture(16, segs, lit, bad);
    compared += 2;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_1234: got %b, expected 0", overflow); end
    if (lit[3] !== 1'b1 || segs[3] !== 7'b1111001) begin
      mismatched++;
      $display("FAIL digit3_1234: got lit=%b seg=%b, expected lit=1 seg=1111001", lit[3], segs[3]);
    end
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (lit[d] !== 1'b1 || segs[d] !== expSeg(1234, d)) begin
        mismatched++;
        $display("FAIL digit_1234[%0d]: got lit=%b seg=%b, expected seg=%b", d, lit[d], segs[d], expSeg(1234, d));
      end
    end
  endtask

  task automatic test_conversion();
    int vals[12];
    int bc;
    logic [3:0][6:0] segs;
    logic [3:0] lit;
    bit bad;
    vals[0] = 0; vals[1] = 5; vals[2] = 100; vals[3] = 9999; vals[4] = 10000; vals[5] = 16383;
    for (int i = 6; i < 12; i++) vals[i] = int'($urandom_range(0, 16383));
    for (int i = 0; i < 12; i++) begin
      align_idle();
      value = 14'(vals[i]);
      wait_conv(bc);
      capture(16, segs, lit, bad);
      compared += 2;
      if (overflow !== (vals[i] > 9999)) begin
        mismatched++;
        $display("FAIL conv_ovf value=%0d: got %b, expected %b", vals[i], overflow, vals[i] > 9999);
      end
      if (bad) begin mismatched++; $display("FAIL conv_an value=%0d: saw multi-digit enable, expected one-hot-low", vals[i]); end
      for (int d = 0; d < 4; d++) begin
        compared++;
        if (expLit(vals[i], d)) begin
          if (lit[d] !== 1'b1 || segs[d] !== expSeg(vals[i], d)) begin
            mismatched++;
            $display("FAIL conv_digit value=%0d d=%0d: got lit=%b seg=%b, expected lit=1 seg=%b",
                     vals[i], d, lit[d], segs[d], expSeg(vals[i], d));
          end
        end else if (lit[d] !== 1'b0) begin
          mismatched++;
          $display("FAIL conv_blank value=%0d d=%0d: got lit=%b, expected 0", vals[i], d, lit[d]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int bc;
    int n = 0;
    logic [3:0][6:0] segs;
    logic [3:0] lit;
    bit bad;
    align_idle();
    value = 14'd16383;
    wait_conv(bc);
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b, expected 1", overflow); end
    value = 14'd567;
    while (overflow !== 1'b0 && n < 17) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b after %0d cycles, expected 0 within 17", overflow, n); end
    capture(16, segs, lit, bad);
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (expLit(567, d) ? (lit[d] !== 1'b1 || segs[d] !== expSeg(567, d)) : (lit[d] !== 1'b0)) begin
        mismatched++;
        $display("FAIL ovf_567 d=%0d: got lit=%b seg=%b, expected lit=%b seg=%b", d, lit[d], segs[d], expLit(567, d), expSeg(567, d));
      end
    end
  endtask

  task automatic test_scan();
    int bc;
    int start = -1;
    int d0 = -1;
    logic [3:0] hist [48];
    logic [3:0] expAn;
    align_idle();
    value = 14'd8888;
    wait_conv(bc);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      hist[i] = an;
    end
    for (int i = 1; i < 9; i++) if (start < 0 && hist[i] !== hist[i-1]) start = i;
    for (int d = 0; d < 4; d++) if (start >= 0 && hist[start] === (4'b1111 ^ (4'b0001 << d))) d0 = d;
    compared++;
    if (start < 0 || d0 < 0) begin
      mismatched++;
      $display("FAIL scan_phase: got start=%0d digit=%0d, expected a valid digit change within 8 cycles", start, d0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < 4; j++) begin
          expAn = 4'b1111 ^ (4'b0001 << ((d0 + k) % 4));
          compared++;
          if (hist[start + 4*k + j] !== expAn) begin
            mismatched++;
            $display("FAIL scan_an run=%0d pos=%0d: got %b, expected %b", k, j, hist[start + 4*k + j], expAn);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int bc;
    logic [3:0][6:0] segs;
    logic [3:0] lit;
    bit bad;
    align_idle();
    value = 14'd45;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    compared += 4;
    if (an !== 4'b1111) begin mismatched++; $display("FAIL midrst_an: got %b, expected 1111", an); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    if (seg !== 7'b1111111) begin mismatched++; $display("FAIL midrst_seg: got %b, expected 1111111", seg); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL midrst_ovf: got %b, expected 0", overflow); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    compared += 2;
    if (an !== 4'b1110) begin mismatched++; $display("FAIL midrst_rel_an: got %b, expected 1110", an); end
    if (seg !== 7'b1000000) begin mismatched++; $display("FAIL midrst_rel_seg: got %b, expected 1000000", seg); end
    @(negedge clk);
    wait_conv(bc);
    compared++;
    if (bc + 1 > 18) begin mismatched++; $display("FAIL midrst_latency: got %0d cycles, expected <= 18", bc + 1); end
    capture(16, segs, lit, bad);
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (expLit(45, d) ? (lit[d] !== 1'b1 || segs[d] !== expSeg(45, d)) : (lit[d] !== 1'b0)) begin
        mismatched++;
        $display("FAIL midrst_45 d=%0d: got lit=%b seg=%b, expected lit=%b seg=%b", d, lit[d], segs[d], expLit(45, d), expSeg(45, d));
      end
    end
  endtask

  task automatic test_value_change();
    int bc;
    logic [3:0][6:0] segs;
    logic [3:0] lit;
    bit bad;
    align_idle();
    value = 14'd45;
    repeat (5) @(negedge clk);
    value = 14'd128;
    wait_conv(bc);
    capture(16, segs, lit, bad);
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (expLit(45, d) ? (lit[d] !== 1'b1 || segs[d] !== expSeg(45, d)) : (lit[d] !== 1'b0)) begin
        mismatched++;
        $display("FAIL chg_first d=%0d: got lit=%b seg=%b, expected lit=%b seg=%b", d, lit[d], segs[d], expLit(45, d), expSeg(45, d));
      end
    end
    capture(16, segs, lit, bad);
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (expLit(128, d) ? (lit[d] !== 1'b1 || segs[d] !== expSeg(128, d)) : (lit[d] !== 1'b0)) begin
        mismatched++;
        $display("FAIL chg_next d=%0d: got lit=%b seg=%b, expected lit=%b seg=%b", d, lit[d], segs[d], expLit(128, d), expSeg(128, d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_busy_1234();
    test_conversion();
    test_overflow();
    test_scan();
    test_reset_mid_shift();
    test_value_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_driver.md
SEVEN_SEG_DISPLAY_DRIVER -- requirements
Module: seven_seg_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is lit (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port value, input, 14 bits: unsigned quantity from the display mux (steps, distance, rate).
REQ-005 SHALL have port busy, output, 1 bit: high while a binary-to-BCD conversion is in progress.
REQ-006 SHALL have port overflow, output, 1 bit: high when the displayed sample exceeded 9999.
REQ-007 SHALL have port an, output, 4 bits: digit enables, active-low; bit 0 is the rightmost digit.
REQ-008 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 SHALL run a conversion FSM with states IDLE, SHIFT and LATCH.
REQ-010 IDLE SHALL sample value into a 14-bit shift register, clear the BCD accumulator and go to SHIFT on every clock edge; no start strobe.
REQ-011 SHALL saturate the sample to 9999 when value > 9999, set a pending overflow bit, and clear it otherwise.
REQ-012 SHIFT SHALL run double-dabble for exactly 14 cycles: add 3 to each nibble >= 5, then shift left one bit.
REQ-013 LATCH SHALL copy the 16-bit BCD into the display register and the pending bit into overflow in one cycle, then return to IDLE.
REQ-014 Latency SHALL be 16 cycles from sampling to display-register update; busy SHALL be high in SHIFT and LATCH.
REQ-015 A value change during SHIFT SHALL NOT affect the conversion in flight; the next IDLE picks it up.
REQ-016 A 20-bit refresh counter SHALL wrap at REFRESH_DIV-1, and a 2-bit digit index SHALL advance on each wrap from 0 to 3, then back to 0.
REQ-017 an SHALL drive the indexed digit low and all others high: 1110, 1101, 1011, 0111.
REQ-018 seg SHALL decode the indexed BCD nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 A nibble value of 10..15 SHALL decode to 1111111 (blank).
REQ-020 The display register SHALL change only in LATCH, so no partially converted digit is ever shown.

Reset
REQ-021 While reset_n is low, the FSM SHALL be in IDLE and all counters and registers SHALL be zero.
REQ-022 While reset_n is low, outputs SHALL be: busy=0, overflow=0, an=1111, seg=1111111.
REQ-023 Reset asserted mid-SHIFT SHALL abort the conversion and leave the display register unchanged from its reset value.
REQ-024 On the first clk edge after reset_n rises, the block SHALL enter normal operation with digit index 0.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, a zero digit with no nonzero digit to its left SHALL drive an=1111 for its slot; digit 0 is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be lit, including leading zeros.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the segment constant table, MAX_DISPLAY=9999 and DIGITS=4.
REQ-028 SHALL instantiate one sub-module, bcd_to_seg7: a combinational nibble-to-segment decoder.
REQ-029 The conversion FSM and the scan logic SHALL be separate always blocks in the top module.

Verification (REFRESH_DIV=4)
REQ-030 value=1234 held -> busy for 15 cycles, then digits 1,2,3,4; digit 3 shows seg=1111001 while an=0111; overflow=0.
REQ-031 value=16383 -> display 9999, overflow=1; then value=567 -> overflow=0 within 17 cycles, display 0567.
REQ-032 value=0 with LEADING_ZERO_BLANK_EN -> only an=1110 is ever asserted, with seg=1000000; without the macro -> all four digits show 0.
REQ-033 Free-running scan -> an cycles 1110, 1101, 1011, 0111 with each state lasting exactly 4 cycles.
REQ-034 reset_n low at cycle 7 of SHIFT with value=45 -> an=1111, busy=0 immediately; after release, the display shows 0045 within 18 cycles.
REQ-035 value stepped 45 to 128 mid-SHIFT -> first latched result is 45 (with blanking: blank, blank, 4, 5); the next latched result is 128.
